// File: rtl/pwm_gate_pkg.sv
// Shared types and constants for the PWM dead-time gate stage.
// Holds the channel state encoding, the default dead-time width and the synchronizer depth.
package pwm_gate_pkg;

    localparam int DT_WIDTH_DEF = 8;
    localparam int SYNC_DEPTH   = 2;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_DT  = 2'd1,
        ST_HS  = 2'd2,
        ST_LS  = 2'd3
    } ch_state_e;

endpackage

// File: rtl/pwm_gate_channel.sv
// Single half-bridge channel: OFF/DT/HS/LS state machine with a dead-time down-counter.
// Gate outputs are registered decodes of the next state.
module pwm_gate_channel
    import pwm_gate_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                drive_ok,
    input  logic                pwm,
    input  logic [DT_WIDTH-1:0] dead_time,
    output logic                gate_hi,
    output logic                gate_lo
);

    ch_state_e           state_q, state_d;
    logic                target_q, target_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                gate_hi_q, gate_hi_d;
    logic                gate_lo_q, gate_lo_d;
    logic                cnt_done;

    assign cnt_done = (cnt_q == '0) || (cnt_q == DT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            target_q  <= 1'b0;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (!drive_ok) begin
            state_d = ST_OFF;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    target_d = pwm;
                    cnt_d    = dead_time;
                    state_d  = ST_DT;
                end
                ST_DT: begin
                    // A PWM change inside the dead band restarts the count.
                    if (pwm != target_q) begin
                        target_d = pwm;
                        cnt_d    = dead_time;
                    end else if (cnt_done) begin
                        state_d = target_q ? ST_HS : ST_LS;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                ST_HS: begin
                    if (!pwm) begin
                        target_d = 1'b0;
                        cnt_d    = dead_time;
                        state_d  = ST_DT;
                    end
                end
                ST_LS: begin
                    if (pwm) begin
                        target_d = 1'b1;
                        cnt_d    = dead_time;
                        state_d  = ST_DT;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_comb begin
        gate_hi_d = (state_d == ST_HS);
        gate_lo_d = (state_d == ST_LS);
    end

    assign gate_hi = gate_hi_q;
    assign gate_lo = gate_lo_q;

endmodule

// File: rtl/pwm_deadtime_gate_stage.sv
// Complementary gate drive with dead time, latched fault shutdown and fault IRQ.
// DEADTIME_PER_CHANNEL_EN gives each channel its own dead-time slice.
module pwm_deadtime_gate_stage
    import pwm_gate_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       enable_i,
    input  logic [NUM_CH-1:0]          pwm_i,
`ifdef DEADTIME_PER_CHANNEL_EN
    input  logic [NUM_CH*DT_WIDTH-1:0] dead_time_i,
`else
    input  logic [DT_WIDTH-1:0]        dead_time_i,
`endif
    input  logic                       fault_ni,
    input  logic                       fault_clear_i,
    output logic [NUM_CH-1:0]          gate_hi_o,
    output logic [NUM_CH-1:0]          gate_lo_o,
    output logic                       fault_o,
    output logic                       irq_o
);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  fault_q, fault_d;
    logic                  irq_q, irq_d;
    logic                  fault_sync;
    logic                  drive_ok;

    assign fault_sync = ~sync_q[SYNC_DEPTH-1];
    assign drive_ok   = enable_i & ~fault_q & ~fault_sync;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q  <= '1;
            fault_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fault_q <= fault_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], fault_ni};
        // Set dominates; clear is ignored while the pin is still low.
        if (fault_sync) begin
            fault_d = 1'b1;
        end else if (fault_clear_i) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
        irq_d = fault_d & ~fault_q;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DT_WIDTH-1:0] ch_dt;
`ifdef DEADTIME_PER_CHANNEL_EN
        assign ch_dt = dead_time_i[c*DT_WIDTH +: DT_WIDTH];
`else
        assign ch_dt = dead_time_i;
`endif
        pwm_gate_channel #(
            .DT_WIDTH (DT_WIDTH)
        ) u_ch (
            .clk       (wb_clk_i),
            .rst_n     (wb_rst_ni),
            .drive_ok  (drive_ok),
            .pwm       (pwm_i[c]),
            .dead_time (ch_dt),
            .gate_hi   (gate_hi_o[c]),
            .gate_lo   (gate_lo_o[c])
        );
    end

    assign fault_o = fault_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_pwm_deadtime_gate_stage.sv
// Directed plus randomized bench for pwm_deadtime_gate_stage against a run-length timing model.
// DEADTIME_PER_CHANNEL_EN selects the per-channel dead-time bus and the staggered test.
module tb_pwm_deadtime_gate_stage;

    localparam int NUM_CH = 4;
    localparam int DTW    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NUM_CH-1:0] pwm;
`ifdef DEADTIME_PER_CHANNEL_EN
    logic [NUM_CH*DTW-1:0] dead_time;
`else
    logic [DTW-1:0]        dead_time;
`endif
    logic              pin;
    logic              clr;
    logic [NUM_CH-1:0] gate_hi_o, gate_lo_o;
    logic              fault_o, irq_o;

    int tests = 0;
    int fails = 0;

    pwm_deadtime_gate_stage #(.NUM_CH(NUM_CH), .DT_WIDTH(DTW)) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .enable_i      (en),
        .pwm_i         (pwm),
        .dead_time_i   (dead_time),
        .fault_ni      (pin),
        .fault_clear_i (clr),
        .gate_hi_o     (gate_hi_o),
        .gate_lo_o     (gate_lo_o),
        .fault_o       (fault_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: timing expressed as "edges since the last load".
    int                edge_n;
    int                load_e [NUM_CH];
    int                load_n [NUM_CH];
    bit                armed  [NUM_CH];
    bit                last_p [NUM_CH];
    bit                pin_m1, pin_m2, flt_m;
    logic [NUM_CH-1:0] exp_hi, exp_lo;
    logic              exp_f, exp_irq;

    function automatic int dt_of(int c);
`ifdef DEADTIME_PER_CHANNEL_EN
        return int'(dead_time[c*DTW +: DTW]);
`else
        return int'(dead_time);
`endif
    endfunction

    task automatic set_dt_all(int v);
`ifdef DEADTIME_PER_CHANNEL_EN
        for (int c = 0; c < NUM_CH; c++) dead_time[c*DTW +: DTW] = DTW'(v);
`else
        dead_time = DTW'(v);
`endif
    endtask

    task automatic model_reset();
        pin_m1 = 1; pin_m2 = 1; flt_m = 0;
        exp_hi = '0; exp_lo = '0; exp_f = 0; exp_irq = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            armed[c] = 0; load_e[c] = 0; load_n[c] = 1; last_p[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit fs, dok, fnew;
        int d;
        fs   = !pin_m2;
        dok  = en && !flt_m && !fs;
        fnew = fs ? 1'b1 : (clr ? 1'b0 : flt_m);
        exp_irq = fnew && !flt_m;
        exp_f   = fnew;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_hi[c] = 0;
            exp_lo[c] = 0;
            if (!dok) begin
                armed[c] = 0;
            end else begin
                if (!armed[c] || pwm[c] != last_p[c]) begin
                    d = dt_of(c);
                    load_e[c] = edge_n;
                    load_n[c] = (d == 0) ? 1 : d;
                    armed[c]  = 1;
                end
                if (edge_n - load_e[c] >= load_n[c]) begin
                    exp_hi[c] = pwm[c];
                    exp_lo[c] = !pwm[c];
                end
            end
            last_p[c] = pwm[c];
        end
        pin_m2 = pin_m1;
        pin_m1 = pin;
        flt_m  = fnew;
        edge_n++;
    endtask

    task automatic check_all();
        tests++;
        assert (gate_hi_o === exp_hi) else begin
            fails++;
            $error("FAIL gate_hi got %b exp %b edge %0d", gate_hi_o, exp_hi, edge_n);
        end
        tests++;
        assert (gate_lo_o === exp_lo) else begin
            fails++;
            $error("FAIL gate_lo got %b exp %b edge %0d", gate_lo_o, exp_lo, edge_n);
        end
        tests++;
        assert (fault_o === exp_f) else begin
            fails++;
            $error("FAIL fault got %b exp %b edge %0d", fault_o, exp_f, edge_n);
        end
        tests++;
        assert (irq_o === exp_irq) else begin
            fails++;
            $error("FAIL irq got %b exp %b edge %0d", irq_o, exp_irq, edge_n);
        end
        tests++;
        assert ((gate_hi_o & gate_lo_o) === '0) else begin
            fails++;
            $error("FAIL overlap hi %b lo %b edge %0d", gate_hi_o, gate_lo_o, edge_n);
        end
    endtask

    task automatic expect_v(string tag, logic [NUM_CH-1:0] obs, logic [NUM_CH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %b exp %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin : main
        int irq_cnt;
        logic hi_seen;
        logic [NUM_CH-1:0] stag;

        rst_n = 0; en = 0; pwm = '0; pin = 1; clr = 0; edge_n = 0;
        set_dt_all(3);
        model_reset();
        #12;
        expect_v("rst_hi", gate_hi_o, '0);
        expect_v("rst_lo", gate_lo_o, '0);
        expect_v("rst_flt", {3'b0, fault_o}, '0);
        expect_v("rst_irq", {3'b0, irq_o}, '0);
        @(negedge clk);
        rst_n = 1;

        // dead time 3, channel 0 low -> high
        en = 1;
        repeat (6) step();
        expect_v("ls0", {3'b0, gate_lo_o[0]}, 4'b1);
        pwm[0] = 1;
        step();
        expect_v("lo0_drop", {3'b0, gate_lo_o[0]}, 4'b0);
        step(); step();
        expect_v("hi0_wait", {3'b0, gate_hi_o[0]}, 4'b0);
        step();
        expect_v("hi0_rise", {3'b0, gate_hi_o[0]}, 4'b1);

        // dead time 0: one all-off cycle per transition
        set_dt_all(0);
        for (int k = 0; k < 6; k++) begin
            pwm = ~pwm;
            step();
            expect_v("dt0_off", gate_hi_o | gate_lo_o, '0);
            step();
            expect_v("dt0_on", gate_hi_o | gate_lo_o, '1);
            step(); step();
        end

        // short pulse shorter than dead time is swallowed
        set_dt_all(5);
        pwm = '0;
        repeat (8) step();
        pwm[1] = 1;
        hi_seen = 0;
        step(); hi_seen |= gate_hi_o[1];
        step(); hi_seen |= gate_hi_o[1];
        pwm[1] = 0;
        for (int k = 0; k < 7; k++) begin
            step();
            hi_seen |= gate_hi_o[1];
        end
        expect_v("short_hi", {3'b0, hi_seen}, 4'b0);
        expect_v("short_ls", {3'b0, gate_lo_o[1]}, 4'b1);

        // fault shutdown, clear blocked while pin low, then restart
        set_dt_all(2);
        pwm = '1;
        repeat (6) step();
        expect_v("pre_fault_hs", gate_hi_o, '1);
        pin = 0;
        irq_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            irq_cnt += int'(irq_o);
        end
        expect_v("fault_gates", gate_hi_o | gate_lo_o, '0);
        expect_v("fault_set", {3'b0, fault_o}, 4'b1);
        clr = 1;
        step(); irq_cnt += int'(irq_o);
        clr = 0;
        step(); irq_cnt += int'(irq_o);
        expect_v("fault_hold", {3'b0, fault_o}, 4'b1);
        expect_v("irq_once", 4'(irq_cnt), 4'd1);
        pin = 1;
        repeat (3) step();
        clr = 1;
        step();
        clr = 0;
        expect_v("fault_clr", {3'b0, fault_o}, 4'b0);
        repeat (5) step();
        expect_v("restart_hs", gate_hi_o, '1);

        // async reset mid dead time
        set_dt_all(7);
        pwm[1] = 0;
        step(); step();
        expect_v("pre_rst_hi0", {3'b0, gate_hi_o[0]}, 4'b1);
        rst_n = 0;
        #1;
        expect_v("arst_hi", gate_hi_o, '0);
        expect_v("arst_lo", gate_lo_o, '0);
        @(negedge clk);
        rst_n = 1;
        model_reset();

`ifdef DEADTIME_PER_CHANNEL_EN
        pwm = '0;
        dead_time = {8'd8, 8'd4, 8'd2, 8'd1};
        repeat (12) step();
        pwm = '1;
        step();
        expect_v("stag_off", gate_hi_o | gate_lo_o, '0);
        for (int k = 1; k <= 8; k++) begin
            step();
            stag = {k >= 8, k >= 4, k >= 2, k >= 1};
            expect_v("stag_hi", gate_hi_o, stag);
        end
`endif

        // randomized run
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 5) == 0) pwm[c] = ~pwm[c];
            if ($urandom_range(0, 7) == 0) begin
`ifdef DEADTIME_PER_CHANNEL_EN
                for (int c = 0; c < NUM_CH; c++)
                    dead_time[c*DTW +: DTW] = DTW'($urandom_range(0, 6));
`else
                dead_time = DTW'($urandom_range(0, 6));
`endif
            end
            if ($urandom_range(0, 49) == 0) en = ~en;
            if (pin) begin
                if ($urandom_range(0, 59) == 0) pin = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                pin = 1;
            end
            clr = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_gate_stage.md
Name: pwm_deadtime_gate_stage

Overview:
- Downstream stage of the quad PWM core; sits between the raw per-channel PWM waveforms and the FET gate pads.
- Converts each PWM bit into a complementary high-side/low-side gate pair with programmable dead time, so both FETs of a half-bridge are never on together.
- Provides a latched fault shutdown driven by an external active-low fault pin and a one-cycle IRQ pulse.
- Runs entirely in the Wishbone clock domain.

Parameters:
- NUM_CH, 4, number of half-bridge channels.
- DT_WIDTH, 8, width of the dead-time count, in clock cycles.

Ports:
- wb_clk_i  in  1  system clock (Wishbone clock).
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  global drive enable, synchronous to wb_clk_i.
- pwm_i  in  NUM_CH  PWM waveform from the PWM core; 1 requests high side, 0 requests low side.
- dead_time_i  in  DT_WIDTH  dead-time cycles, shared by all channels.
- fault_ni  in  1  external fault pin, asynchronous, active-low.
- fault_clear_i  in  1  one-cycle pulse that clears the latched fault.
- gate_hi_o  out  NUM_CH  high-side gate drive, registered.
- gate_lo_o  out  NUM_CH  low-side gate drive, registered.
- fault_o  out  1  latched fault status.
- irq_o  out  1  one-cycle pulse on the rising edge of fault_o.

Behaviour:
- Reset (async assert, sync deassert at the wrapper level):
  - All gate_hi_o and gate_lo_o = 0; fault_o = 0; irq_o = 0.
  - Every channel FSM in OFF.
  - Fault synchronizer flops reset to "no fault" (value 1).
- fault_ni passes through a 2-flop synchronizer. fault_sync = 1 when the synchronized pin is low.
- fault_o:
  - Sets the cycle after fault_sync = 1.
  - Clears on fault_clear_i only when fault_sync = 0.
  - If set and clear occur in the same cycle, set wins.
  - irq_o = fault_o & ~fault_o_prev.
- drive_ok = enable_i & ~fault_o & ~fault_sync.
- Per-channel FSM, states OFF, DT, HS, LS. Each channel has a target bit and a DT_WIDTH down-counter.
  - OFF: both gates 0. If drive_ok: target <= pwm_i[c], cnt <= dead_time_i, go to DT.
  - DT: both gates 0.
    - If pwm_i[c] != target: target <= pwm_i[c], cnt <= dead_time_i (dead time restarts).
    - Else if cnt <= 1: go to HS if target = 1, LS if target = 0.
    - Else cnt <= cnt - 1.
  - HS: gate_hi = 1. If pwm_i[c] = 0: target <= 0, cnt <= dead_time_i, go to DT.
  - LS: gate_lo = 1. If pwm_i[c] = 1: target <= 1, cnt <= dead_time_i, go to DT.
  - In any state, drive_ok = 0 forces OFF on the next edge. This has priority over all other transitions.
- Gate outputs are registered decodes of the next state, so they change on the same edge the state changes.
- Latency:
  - PWM edge sampled at edge N: the active gate drops at N+1; the opposite gate rises at N+1+max(dead_time_i,1).
  - dead_time_i = 0 behaves as 1, so there is always at least one all-off cycle.
- PWM pulses shorter than the dead time keep the channel in DT; no gate pulse is produced.
- Invariant: gate_hi_o[c] & gate_lo_o[c] = 0 on every cycle, including reset and mid-dead-time changes to dead_time_i.
- dead_time_i is sampled only when cnt is loaded; changes mid-count do not affect the count in progress.

Optional Feature:
- Macro DEADTIME_PER_CHANNEL_EN.
- Defined: dead_time_i widens to NUM_CH*DT_WIDTH; channel c loads slice [c*DT_WIDTH +: DT_WIDTH].
- Undefined: a single shared DT_WIDTH value loads into all channels.
- All other behaviour is identical.

Decomposition:
- Package pwm_gate_pkg holds:
  - the state enum (OFF, DT, HS, LS), 2-bit encoding;
  - the DT_WIDTH default;
  - the synchronizer depth constant (2).
- One sub-module, pwm_gate_channel: a single-channel FSM plus counter, instantiated NUM_CH times.
- The top level holds the fault synchronizer, fault latch and IRQ logic.

Test Plan:
- Reset, then enable_i=1, dead_time_i=3, pwm_i[0] 0->1: gate_lo_o[0] falls 1 cycle after the edge; gate_hi_o[0] rises 3 cycles later; never both 1.
- dead_time_i=0 with pwm_i toggling every 4 cycles: exactly 1 all-off cycle at each transition.
- dead_time_i=5 with a 2-cycle high pulse on pwm_i[1] from LS: gate_lo_o[1] drops, channel stays in DT, returns to LS with gate_hi_o[1] never asserted.
- Drive fault_ni low while channels are in HS: all gates 0 by the 3rd edge after the pin falls; fault_o=1; irq_o pulses once. fault_clear_i while the pin is still low: fault_o stays 1. Release the pin, then pulse fault_clear_i: fault_o=0 and channels restart through DT.
- Assert wb_rst_ni low mid-dead-time with gate_hi_o set on another channel: all outputs 0 immediately, without waiting for a clock edge.
- With DEADTIME_PER_CHANNEL_EN, per-channel dead times of 1/2/4/8 and a common pwm_i edge: the four gates rise at staggered cycles 1/2/4/8 after the off edge.
